// File: rtl/uart_tx_fifo_feeder.sv
`timescale 1ns/1ps
// uart_tx_fifo_feeder
//   Byte FIFO plus send sequencer that drains queued bytes, in order, into a
//   uart_transmitter data/send/busy handshake.
// Ports:
//   clk, reset          rising-edge clock, async active-high reset
//   wr_data, wr_en      producer push interface (one byte per cycle)
//   full, empty, count  registered FIFO occupancy status
//   overflow            sticky flag: a push was dropped while full
//   tx_timeout          one-cycle pulse: transmitter busy never rose after a send
//   tx_data, tx_send    byte and one-cycle send strobe to the transmitter
//   tx_busy             transmitter busy input
module uart_tx_fifo_feeder #(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned DEPTH_LOG2    = 4,
  parameter int unsigned BUSY_WAIT_MAX = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_en,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  output logic                  tx_timeout,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_send,
  input  logic                  tx_busy
);

  localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
  localparam int unsigned CW    = DEPTH_LOG2 + 1;
  localparam int unsigned WW    = $clog2(BUSY_WAIT_MAX + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND    = 2'd1,
    WAIT_HI = 2'd2,
    WAIT_LO = 2'd3
  } state_t;

  state_t                  state;
  state_t                  next_state;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic [DEPTH_LOG2-1:0]   wr_ptr;
  logic [DEPTH_LOG2-1:0]   rd_ptr;
  logic [WW-1:0]           wait_cnt;
  logic [CW-1:0]           count_nxt;

  logic push_c;
  logic pop_c;
  logic wait_last_c;
  logic send_nxt_c;
  logic timeout_nxt_c;
  logic wait_clr_c;
  logic wait_inc_c;

  // A push while full is dropped even if a pop happens on the same edge.
  assign push_c      = wr_en & ~full;
  assign pop_c       = (state == IDLE) & ~empty & ~tx_busy;
  assign wait_last_c = (wait_cnt == WW'(BUSY_WAIT_MAX - 1));
  assign count_nxt   = CW'(count + CW'(push_c) - CW'(pop_c));

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (pop_c) next_state = SEND;
      SEND:    next_state = WAIT_HI;
      WAIT_HI: begin
        if (tx_busy)          next_state = WAIT_LO;
        else if (wait_last_c) next_state = IDLE;
      end
      WAIT_LO: if (!tx_busy) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output decode; results are registered below so all outputs leave flops.
  always_comb begin
    send_nxt_c    = 1'b0;
    timeout_nxt_c = 1'b0;
    wait_clr_c    = 1'b0;
    wait_inc_c    = 1'b0;
    send_nxt_c    = (next_state == SEND);
    wait_clr_c    = (state == SEND);
    if (state == WAIT_HI && !tx_busy) begin
      wait_inc_c    = 1'b1;
      timeout_nxt_c = wait_last_c;
    end
  end

  // FIFO storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push_c) mem[wr_ptr] <= wr_data;
  end

  // Pointers, occupancy and sticky overflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      empty    <= 1'b1;
      full     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      if (pop_c)  rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
      count <= count_nxt;
      empty <= (count_nxt == '0);
      full  <= (count_nxt == CW'(DEPTH));
      if (wr_en && full) overflow <= 1'b1;
    end
  end

  // Transmitter-facing registers and busy-rise wait counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_data    <= '0;
      tx_send    <= 1'b0;
      tx_timeout <= 1'b0;
      wait_cnt   <= '0;
    end else begin
      tx_send    <= send_nxt_c;
      tx_timeout <= timeout_nxt_c;
      if (pop_c) tx_data <= mem[rd_ptr];
      if (wait_clr_c)      wait_cnt <= '0;
      else if (wait_inc_c) wait_cnt <= wait_cnt + WW'(1);
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo_feeder.sv
`timescale 1ns/1ps
// Bench for uart_tx_fifo_feeder: queue-based reference model, per-cycle output
// compare, directed scenarios with literal expectations, then random traffic
// against a simple transmitter responder.
module tb_uart_tx_fifo_feeder;

  localparam int DEPTH    = 16;
  localparam int WAIT_MAX = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] wr_data;
  logic       wr_en;
  logic       full, empty, overflow, tx_timeout, tx_send;
  logic [4:0] count;
  logic [7:0] tx_data;
  logic       tx_busy;

  uart_tx_fifo_feeder #(.DATA_WIDTH(8), .DEPTH_LOG2(4), .BUSY_WAIT_MAX(WAIT_MAX)) dut (
    .clk(clk), .reset(reset), .wr_data(wr_data), .wr_en(wr_en),
    .full(full), .empty(empty), .count(count), .overflow(overflow),
    .tx_timeout(tx_timeout), .tx_data(tx_data), .tx_send(tx_send), .tx_busy(tx_busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model: byte queue plus the handshake phase of the byte in flight.
  logic [7:0] mq[$];
  logic [7:0] m_data;
  bit m_ovf, m_send, m_tmo, m_rise, m_fall;
  int m_wait;

  // Observations of the DUT for directed checks.
  logic [7:0] sent_q[$];
  int send_cyc[$];
  int tmo_cyc[$];

  // Transmitter responder.
  bit auto_busy = 0;
  int rise_in = -1, hi_left = 0, hi_len = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_data = 8'h00; m_ovf = 0; m_send = 0; m_tmo = 0; m_rise = 0; m_fall = 0; m_wait = 0;
    rise_in = -1; hi_left = 0;
  endtask

  function automatic bit model_idle();
    return !m_send && !m_rise && !m_fall;
  endfunction

  // One clock edge of the specified behaviour, from the inputs seen at the edge.
  task automatic model_step();
    int  old_size = mq.size();
    bit  b = tx_busy;
    bit  push_ok = wr_en && (old_size < DEPTH);
    bit  nsend = 0, ntmo = 0;
    if (wr_en && old_size >= DEPTH) m_ovf = 1;
    if (m_send) begin
      m_rise = 1; m_wait = 0;
    end else if (m_rise) begin
      if (b) begin m_rise = 0; m_fall = 1; end
      else begin
        m_wait++;
        if (m_wait == WAIT_MAX) begin m_rise = 0; ntmo = 1; end
      end
    end else if (m_fall) begin
      if (!b) m_fall = 0;
    end else if (old_size > 0 && !b) begin
      m_data = mq.pop_front();
      nsend  = 1;
    end
    m_send = nsend;
    m_tmo  = ntmo;
    if (push_ok) mq.push_back(wr_data);
  endtask

  task automatic check_all();
    chk("count",      32'(count),      32'(mq.size()));
    chk("empty",      32'(empty),      32'(mq.size() == 0));
    chk("full",       32'(full),       32'(mq.size() == DEPTH));
    chk("overflow",   32'(overflow),   32'(m_ovf));
    chk("tx_data",    32'(tx_data),    32'(m_data));
    chk("tx_send",    32'(tx_send),    32'(m_send));
    chk("tx_timeout", 32'(tx_timeout), 32'(m_tmo));
  endtask

  // Busy rises 0..2 cycles after a send and holds 1..5 cycles; sometimes never rises.
  task automatic responder();
    if (m_send) begin
      if ($urandom_range(0, 4) == 0) rise_in = -1;
      else begin
        rise_in = $urandom_range(0, 2);
        hi_len  = $urandom_range(1, 5);
      end
    end
    if (hi_left > 0) begin
      tx_busy = 1'b1; hi_left--;
    end else if (rise_in == 0) begin
      tx_busy = 1'b1; hi_left = hi_len - 1; rise_in = -1;
    end else begin
      tx_busy = 1'b0;
      if (rise_in > 0) rise_in--;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (!reset) model_step();
    @(negedge clk);
    cyc++;
    check_all();
    if (tx_send) begin sent_q.push_back(tx_data); send_cyc.push_back(cyc); end
    if (tx_timeout) tmo_cyc.push_back(cyc);
    if (auto_busy) responder();
  endtask

  task automatic push(input logic [7:0] d);
    wr_en = 1'b1; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while (!(model_idle() && mq.size() == 0) && n < limit) begin tick(); n++; end
    if (n >= limit) begin
      total++; bad++;
      $display("FAIL wait_idle cyc=%0d got=busy expected=idle", cyc);
    end
  endtask

  task automatic clear_obs();
    sent_q.delete(); send_cyc.delete(); tmo_cyc.delete();
  endtask

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_data = 8'h00; tx_busy = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_empty",    32'(empty),    32'd1);
    chk("rst_full",     32'(full),     32'd0);
    chk("rst_count",    32'(count),    32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_tx_send",  32'(tx_send),  32'd0);
    chk("rst_tx_data",  32'(tx_data),  32'h00);
    reset = 1'b0;
    tick();

    // Single byte; busy modelled high for 3 cycles blocks the second byte.
    clear_obs();
    push(8'h8E);
    chk("s1_empty_fall", 32'(empty), 32'd0);
    tick();
    chk("s1_send",  32'(tx_send), 32'd1);
    chk("s1_data",  32'(tx_data), 32'h8E);
    tx_busy = 1'b1;
    push(8'h55);
    chk("s1_send_low", 32'(tx_send), 32'd0);
    repeat (2) tick();
    chk("s1_no_second", 32'(send_cyc.size()), 32'd1);
    tx_busy = 1'b0;
    repeat (4) tick();
    chk("s1_second", 32'(send_cyc.size()), 32'd2);
    chk("s1_second_data", 32'(sent_q[1]), 32'h55);
    wait_idle(100);

    // Fill past capacity while the transmitter is busy.
    tx_busy = 1'b1;
    for (int i = 0; i <= 16; i++) push(8'(i));
    chk("s2_count",    32'(count),    32'd16);
    chk("s2_full",     32'(full),     32'd1);
    chk("s2_overflow", 32'(overflow), 32'd1);
    clear_obs();
    auto_busy = 1;
    for (int n = 0; n < 1000 && sent_q.size() < 16; n++) tick();
    chk("s2_nsent", 32'(sent_q.size()), 32'd16);
    for (int i = 0; i < 16; i++) chk("s2_order", 32'(sent_q[i]), 32'(i));
    wait_idle(200);

    // Prefill 3, then push on the pop edge; repeated so pointers wrap several times.
    for (int r = 0; r < 8; r++) begin
      auto_busy = 0; rise_in = -1; hi_left = 0;
      tx_busy = 1'b1;
      for (int i = 0; i < 3; i++) push(8'($urandom));
      tx_busy = 1'b0; wr_en = 1'b1; wr_data = 8'($urandom);
      auto_busy = 1;
      tick();
      wr_en = 1'b0;
      chk("s3_count", 32'(count),   32'd3);
      chk("s3_send",  32'(tx_send), 32'd1);
      wait_idle(300);
    end

    // Busy never rises: timeout after the wait window, then the next byte goes.
    auto_busy = 0; rise_in = -1; hi_left = 0; tx_busy = 1'b0;
    clear_obs();
    push(8'hA1);
    push(8'hB2);
    repeat (20) tick();
    chk("s4_nsend", 32'(send_cyc.size()), 32'd2);
    chk("s4_ntmo",  32'(tmo_cyc.size()),  32'd2);
    chk("s4_tmo_delay",  32'(tmo_cyc[0] - send_cyc[0]),  32'd5);
    chk("s4_next_send",  32'(send_cyc[1] - send_cyc[0]), 32'd6);
    chk("s4_data", 32'(sent_q[1]), 32'hB2);

    // Reset while waiting for busy to fall with 5 bytes queued.
    clear_obs();
    for (int i = 0; i < 6; i++) push(8'h30 + 8'(i));
    tx_busy = 1'b1;
    repeat (3) tick();
    chk("s5_queued", 32'(count), 32'd5);
    #2 reset = 1'b1;
    #1;
    chk("s5_rst_empty", 32'(empty),   32'd1);
    chk("s5_rst_send",  32'(tx_send), 32'd0);
    chk("s5_rst_count", 32'(count),   32'd0);
    model_reset();
    tx_busy = 1'b0;
    tick();
    reset = 1'b0;
    clear_obs();
    repeat (10) tick();
    chk("s5_no_send", 32'(send_cyc.size()), 32'd0);
    push(8'h77);
    repeat (2) tick();
    chk("s5_new_send", 32'(send_cyc.size()), 32'd1);
    chk("s5_new_data", 32'(tx_data), 32'h77);
    wait_idle(100);

    // Random traffic.
    auto_busy = 1;
    for (int n = 0; n < 3000; n++) begin
      wr_en   = ($urandom_range(0, 5) == 0);
      wr_data = 8'($urandom);
      tick();
    end
    wr_en = 1'b0;
    wait_idle(1000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
